// File: rtl/nvram_snapshot_uploader_pkg.sv
// Shared definitions for the NVRAM snapshot uploader: FSM encoding,
// the ioctl index it answers by default, and the read-data source select.
package nvram_snapshot_uploader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE_WAIT,
    S_COPY,
    S_REQ,
    S_SERVE
  } state_e;

  typedef enum logic {
    DIN_FF,
    DIN_BUF
  } din_src_e;

  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;

endpackage

// File: rtl/nvram_snapshot_uploader_snap_buf.sv
// Simple dual-port snapshot buffer: write port fed by the copy path,
// registered read port feeding the HPS read stream.
module snap_buf #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [2**ADDR_W];

  // NOTE: no reset on the array or its read register, so the tools can map
  // this onto block RAM; contents are only trusted once snap_valid is set.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/nvram_snapshot_uploader.sv
// Pauses the game CPU, copies LEN bytes of RAM into a local buffer, then
// serves that coherent image to the HPS upload stream.
module nvram_snapshot_uploader
  import nvram_snapshot_uploader_pkg::*;
#(
  parameter int         ADDR_W = 11,
  parameter int         LEN    = 64,
  parameter logic [7:0] INDEX  = IOCTL_IDX_NVRAM
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              save_req,
  input  logic              paused,
  output logic              pause_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_din,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic              busy,
  output logic              snap_valid
);

  localparam int               CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);
  localparam logic [24:0]      LEN_A = 25'(LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             snap_valid_q, snap_valid_d;
  logic             upload_q;
  din_src_e         src_q, src_d;

  logic              idx_hit, upload_fall, rd_hit, addr_in_range, buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_rdata;

  assign idx_hit       = (ioctl_index == INDEX);
  assign upload_fall   = upload_q && !ioctl_upload;
  assign rd_hit        = (state_q == S_SERVE) && ioctl_rd && idx_hit;
  assign addr_in_range = (ioctl_addr < LEN_A);
  // Data for the read issued at count c arrives while the count is c+1.
  assign buf_we        = (state_q == S_COPY) && (cnt_q != '0);
  assign buf_waddr     = ADDR_W'(cnt_q - CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (save_req) state_d = S_PAUSE_WAIT;
      S_PAUSE_WAIT: if (paused) state_d = S_COPY;
      S_COPY: begin
        if (!paused)              state_d = S_PAUSE_WAIT;
        else if (cnt_q == LEN_C)  state_d = S_REQ;
      end
      S_REQ:        if (ioctl_upload && idx_hit) state_d = S_SERVE;
      S_SERVE: begin
        if (upload_fall) state_d = (pending_q || save_req) ? S_PAUSE_WAIT : S_IDLE;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pause_req        = 1'b0;
    ram_rd           = 1'b0;
    ioctl_upload_req = 1'b0;
    unique case (state_q)
      S_PAUSE_WAIT: pause_req = 1'b1;
      S_COPY: begin
        pause_req = 1'b1;
        ram_rd    = (cnt_q < LEN_C);
      end
      S_REQ:        ioctl_upload_req = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    // The counter only advances while staying in COPY; an abort restarts at 0.
    cnt_d = '0;
    if (state_q == S_COPY && state_d == S_COPY) cnt_d = cnt_q + CNT_W'(1);

    pending_d = pending_q;
    if ((state_q == S_REQ || state_q == S_SERVE) && save_req) pending_d = 1'b1;
    if (state_q == S_SERVE && upload_fall)                    pending_d = 1'b0;

    snap_valid_d = snap_valid_q;
    if (state_q == S_PAUSE_WAIT && paused)             snap_valid_d = 1'b0;
    else if (state_q == S_COPY && state_d == S_REQ)    snap_valid_d = 1'b1;

    src_d = src_q;
    if (rd_hit) src_d = addr_in_range ? DIN_BUF : DIN_FF;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      upload_q     <= 1'b0;
      src_q        <= DIN_FF;
    end else begin
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      snap_valid_q <= snap_valid_d;
      upload_q     <= ioctl_upload;
      src_q        <= src_d;
    end
  end

  snap_buf #(.ADDR_W(ADDR_W)) u_snap_buf (
    .clk     (clk_sys),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (ram_din),
    .re_i    (rd_hit && addr_in_range),
    .raddr_i (ioctl_addr[ADDR_W-1:0]),
    .rdata_o (buf_rdata)
  );

  // The buffer read register cannot be reset, so 8'hFF comes from the select.
  assign ioctl_din  = (src_q == DIN_BUF) ? buf_rdata : 8'hFF;
  assign busy       = (state_q != S_IDLE);
  assign ram_addr   = cnt_q[ADDR_W-1:0];
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_nvram_snapshot_uploader.sv
// Directed bench for nvram_snapshot_uploader with a small game RAM model
// and a CPU whose pause acknowledge trails pause_req by three cycles.
module tb_nvram_snapshot_uploader;

  localparam int ADDR_W = 4;
  localparam int LEN    = 4;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              save_req;
  logic              paused;
  logic              pause_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_din;
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_upload_req;
  logic              busy;
  logic              snap_valid;

  logic [7:0] ram [16];
  logic [2:0] pause_sh = '0;
  logic       paused_en;
  int         rd_n = 0;
  int         rd_log [256];
  int         n_assert = 0;
  int         n_fail = 0;
  int         start;

  always #5 clk_sys = ~clk_sys;

  // CPU model: halts three cycles after being asked; paused_en forces a drop.
  always @(posedge clk_sys) pause_sh <= {pause_sh[1:0], pause_req};
  assign paused = pause_sh[2] && paused_en;

  // Game RAM: registered read, data valid the cycle after ram_rd.
  always @(posedge clk_sys) begin
    if (ram_rd) begin
      ram_din        <= ram[ram_addr];
      rd_log[rd_n]   <= int'(ram_addr);
      rd_n           <= rd_n + 1;
    end
  end

  nvram_snapshot_uploader #(.ADDR_W(ADDR_W), .LEN(LEN)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .save_req         (save_req),
    .paused           (paused),
    .pause_req        (pause_req),
    .ram_addr         (ram_addr),
    .ram_rd           (ram_rd),
    .ram_din          (ram_din),
    .ioctl_upload     (ioctl_upload),
    .ioctl_rd         (ioctl_rd),
    .ioctl_index      (ioctl_index),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_upload_req (ioctl_upload_req),
    .busy             (busy),
    .snap_valid       (snap_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_upload_req(input string tag);
    int k = 0;
    while (!ioctl_upload_req && k < 60) begin
      step();
      k++;
    end
    check(tag, ioctl_upload_req, 1'b1);
  endtask

  task automatic wait_reads(input int base, input int n, input string tag);
    int k = 0;
    while ((rd_n - base) < n && k < 60) begin
      step();
      k++;
    end
    check(tag, rd_n - base, n);
  endtask

  task automatic read_check(input logic [24:0] a, input logic [7:0] exp, input string tag);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    step();
    check(tag, ioctl_din, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'hA0 + 8'(i);
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    reset_n = 1'b0; save_req = 1'b0; paused_en = 1'b1;
    ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_index = 8'd0; ioctl_addr = '0;
    step(3);
    check("rst_pause_req", pause_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_snap_valid", snap_valid, 1'b0);
    check("rst_upload_req", ioctl_upload_req, 1'b0);
    check("rst_ioctl_din", ioctl_din, 8'hFF);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_rd", ram_rd, 1'b0);
    reset_n = 1'b1;
    step();

    // Basic snapshot.
    start = rd_n;
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    check("t1_pause_req_1cyc", pause_req, 1'b1);
    check("t1_busy", busy, 1'b1);
    wait_upload_req("t1_upload_req");
    check("t1_rd_count", rd_n - start, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_rd_addr%0d", i), rd_log[start + i], i);
    check("t1_pause_dropped", pause_req, 1'b0);
    check("t1_snap_valid", snap_valid, 1'b1);
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    step();
    check("t1_upload_req_cleared", ioctl_upload_req, 1'b0);
    read_check(25'd0, 8'h11, "t1_rd0");
    read_check(25'd1, 8'h22, "t1_rd1");
    read_check(25'd2, 8'h33, "t1_rd2");
    read_check(25'd3, 8'h44, "t1_rd3");
    read_check(25'd4, 8'hFF, "t1_rd4");
    read_check(25'd5, 8'hFF, "t1_rd5");
    read_check(25'h10001, 8'hFF, "t1_rd_high_addr");
    read_check(25'd2, 8'h33, "t1_rd2_again");
    ioctl_rd = 1'b0;
    step();
    check("t1_din_hold", ioctl_din, 8'h33);
    read_check(25'd5, 8'hFF, "t1_rd5_again");
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    step();
    check("t1_idle", busy, 1'b0);
    check("t1_valid_kept", snap_valid, 1'b1);

    // Pause loss after two copy reads; RAM changes before the re-pause.
    start = rd_n;
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    wait_reads(start, 2, "t2_two_reads");
    paused_en = 1'b0;
    step();
    check("t2_back_to_wait", pause_req, 1'b1);
    check("t2_no_rd", ram_rd, 1'b0);
    check("t2_valid_low", snap_valid, 1'b0);
    ram[0] = 8'h55;
    step(3);
    check("t2_still_waiting", busy, 1'b1);
    check("t2_no_upload_req", ioctl_upload_req, 1'b0);
    start = rd_n;
    paused_en = 1'b1;
    wait_upload_req("t2_upload_req");
    check("t2_rd_count", rd_n - start, 4);
    check("t2_restart_addr0", rd_log[start], 0);
    check("t2_last_addr3", rd_log[start + 3], 3);
    check("t2_snap_valid", snap_valid, 1'b1);

    // Wrong index is ignored.
    ioctl_index = 8'd0; ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    step(3);
    check("t3_upload_req_held", ioctl_upload_req, 1'b1);
    check("t3_din_ff", ioctl_din, 8'hFF);
    ioctl_upload = 1'b0; ioctl_rd = 1'b0;
    step();
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    step();
    check("t3_served", ioctl_upload_req, 1'b0);
    read_check(25'd0, 8'h55, "t3_rd0");
    read_check(25'd3, 8'h44, "t3_rd3");
    ioctl_rd = 1'b0;

    // Pending request raised during SERVE.
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    ram[1] = 8'h66; ram[3] = 8'h77;
    ioctl_upload = 1'b0;
    step();
    check("t4_pause_req", pause_req, 1'b1);
    wait_upload_req("t4_upload_req");
    ioctl_upload = 1'b1;
    step();
    read_check(25'd0, 8'h55, "t4_rd0");
    read_check(25'd1, 8'h66, "t4_rd1");
    read_check(25'd2, 8'h33, "t4_rd2");
    read_check(25'd3, 8'h77, "t4_rd3");
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    step(2);
    check("t4_idle", busy, 1'b0);
    check("t4_no_repeat", pause_req, 1'b0);

    // Reset in the middle of a copy.
    start = rd_n;
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    wait_reads(start, 1, "t5_copy_started");
    reset_n = 1'b0;
    #1;
    check("t5_pause_req_async", pause_req, 1'b0);
    check("t5_busy_async", busy, 1'b0);
    check("t5_valid_async", snap_valid, 1'b0);
    check("t5_upload_req_async", ioctl_upload_req, 1'b0);
    step(2);
    reset_n = 1'b1;
    ioctl_index = 8'd4; ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    step(3);
    check("t5_idle", busy, 1'b0);
    check("t5_rd_ignored", ioctl_din, 8'hFF);
    check("t5_no_upload_req", ioctl_upload_req, 1'b0);
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
